// File: rtl/uart_oversampled_receiver.sv
// UART receive stage: oversamples rx at 13x or 16x baud (tick from an
// external divider), deframes 5..8 data bits, optional parity and 1..2 stop
// bits, and holds the received word plus error flags until it is consumed.
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   baudTick            one-cycle enable per oversample period
//   rx                  asynchronous serial line, idle high
//   overSampling        13 or 16 (anything else means 16)
//   dataWidth           5..8 data bits (anything else means 8)
//   parityEnable        parity bit present
//   parityType          0 = even, 1 = odd
//   stopBits            1 or 2 (anything else means 1)
//   rxReady             consumer accepts the held word
//   rxData              received data, right-justified, upper bits 0
//   rxParity            received parity bit (0 without parity)
//   parityError         parity mismatch
//   breakingError       line held low through data, parity and first stop bit
//   overrunError        previous word was overwritten unread
//   framingError        a stop bit was sampled low
//   rxValid             word and flags valid
module uart_oversampled_receiver #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  baudTick,
    input  logic                  rx,
    input  logic [4:0]            overSampling,
    input  logic [3:0]            dataWidth,
    input  logic                  parityEnable,
    input  logic                  parityType,
    input  logic [1:0]            stopBits,
    input  logic                  rxReady,
    output logic [DATA_WIDTH-1:0] rxData,
    output logic                  rxParity,
    output logic                  parityError,
    output logic                  breakingError,
    output logic                  overrunError,
    output logic                  framingError,
    output logic                  rxValid
);

    localparam int unsigned MAX_BITS   = (DATA_WIDTH < 8) ? DATA_WIDTH : 8;
    localparam logic [3:0]  MAX_BITS_W = 4'(MAX_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAKWAIT
    } stateT;

    stateT                 state;
    logic [4:0]            cnt;
    logic [3:0]            bitIdx;
    logic                  stopIdx;
    logic [DATA_WIDTH-1:0] shiftData;
    logic                  parBit;
    logic                  allZero;
    logic                  frameFraming;
    logic                  frameBreak;
    logic                  commitPend;

    // Frame configuration, captured when a start bit is detected
    logic [4:0]            osCfg;
    logic [3:0]            dwCfg;
    logic                  parEnCfg;
    logic                  parTypeCfg;
    logic                  twoStopCfg;

    logic [SYNC_STAGES-1:0] syncReg;
    logic                   rxSync;
    logic [4:0]             osEff;
    logic [3:0]             dwEff;
    logic [4:0]             midCfg;
    logic [4:0]             cntNext;
    logic                   breakHere;

    // Input synchroniser; idles high so reset does not fake a start bit
    always_ff @(posedge clk) begin
        if (!reset) begin
            syncReg <= '1;
        end else begin
            syncReg <= {syncReg[SYNC_STAGES-2:0], rx};
        end
    end

    assign rxSync = syncReg[SYNC_STAGES-1];

    // Map out-of-range configuration onto the defaults
    assign osEff = (overSampling == 5'd13) ? 5'd13 : 5'd16;

    always_comb begin
        dwEff = 4'd8;
        if (dataWidth >= 4'd5 && dataWidth <= 4'd8) begin
            dwEff = dataWidth;
        end
        if (dwEff > MAX_BITS_W) begin
            dwEff = MAX_BITS_W;
        end
    end

    assign midCfg  = (osCfg == 5'd13) ? 5'd6 : 5'd8;
    assign cntNext = cnt + 5'd1;

    // Break: everything so far was zero and the first stop sample is low too
    assign breakHere = !stopIdx && allZero && !rxSync;

    // Deframing FSM; moves only on oversample ticks
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= 5'd0;
            bitIdx       <= 4'd0;
            stopIdx      <= 1'b0;
            shiftData    <= '0;
            parBit       <= 1'b0;
            allZero      <= 1'b0;
            frameFraming <= 1'b0;
            frameBreak   <= 1'b0;
            commitPend   <= 1'b0;
            osCfg        <= 5'd16;
            dwCfg        <= 4'd8;
            parEnCfg     <= 1'b0;
            parTypeCfg   <= 1'b0;
            twoStopCfg   <= 1'b0;
        end else begin
            commitPend <= 1'b0;
            if (baudTick) begin
                unique case (state)
                    IDLE: begin
                        if (!rxSync) begin
                            state        <= START;
                            cnt          <= 5'd1;
                            osCfg        <= osEff;
                            dwCfg        <= dwEff;
                            parEnCfg     <= parityEnable;
                            parTypeCfg   <= parityType;
                            twoStopCfg   <= (stopBits == 2'd2);
                            shiftData    <= '0;
                            parBit       <= 1'b0;
                            allZero      <= 1'b1;
                            frameFraming <= 1'b0;
                            frameBreak   <= 1'b0;
                        end
                    end
                    START: begin
                        if (cntNext == midCfg) begin
                            if (rxSync) begin
                                state <= IDLE;
                            end else begin
                                state  <= DATA;
                                cnt    <= 5'd0;
                                bitIdx <= 4'd0;
                            end
                        end else begin
                            cnt <= cntNext;
                        end
                    end
                    DATA: begin
                        if (cntNext == osCfg) begin
                            cnt <= 5'd0;
                            for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
                                if (bitIdx == 4'(i)) begin
                                    shiftData[i] <= rxSync;
                                end
                            end
                            if (rxSync) begin
                                allZero <= 1'b0;
                            end
                            bitIdx <= bitIdx + 4'd1;
                            if (bitIdx == dwCfg - 4'd1) begin
                                state   <= parEnCfg ? PARITY : STOP;
                                stopIdx <= 1'b0;
                            end
                        end else begin
                            cnt <= cntNext;
                        end
                    end
                    PARITY: begin
                        if (cntNext == osCfg) begin
                            cnt     <= 5'd0;
                            parBit  <= rxSync;
                            if (rxSync) begin
                                allZero <= 1'b0;
                            end
                            state   <= STOP;
                            stopIdx <= 1'b0;
                        end else begin
                            cnt <= cntNext;
                        end
                    end
                    STOP: begin
                        if (cntNext == osCfg) begin
                            cnt <= 5'd0;
                            if (!rxSync) begin
                                frameFraming <= 1'b1;
                            end
                            if (breakHere) begin
                                frameBreak <= 1'b1;
                            end
                            if (stopIdx || !twoStopCfg) begin
                                commitPend <= 1'b1;
                                state      <= (frameBreak || breakHere) ? BREAKWAIT : IDLE;
                            end else begin
                                stopIdx <= 1'b1;
                            end
                        end else begin
                            cnt <= cntNext;
                        end
                    end
                    BREAKWAIT: begin
                        if (rxSync) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Output word register; a commit always wins over a same-cycle consume
    always_ff @(posedge clk) begin
        if (!reset) begin
            rxData        <= '0;
            rxParity      <= 1'b0;
            parityError   <= 1'b0;
            breakingError <= 1'b0;
            overrunError  <= 1'b0;
            framingError  <= 1'b0;
            rxValid       <= 1'b0;
        end else if (commitPend) begin
            rxData        <= shiftData;
            rxParity      <= parBit;
            // Unused data bits are zero, so the full-width XOR covers dataWidth bits
            parityError   <= parEnCfg & ((^shiftData) ^ parBit ^ parTypeCfg);
            breakingError <= frameBreak;
            framingError  <= frameFraming;
            overrunError  <= rxValid & ~rxReady;
            rxValid       <= 1'b1;
        end else if (rxValid && rxReady) begin
            rxValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_oversampled_receiver.sv
module tb_uart_oversampled_receiver;

    logic       clk;
    logic       reset;
    logic       baudTick;
    logic       rx;
    logic [4:0] overSampling;
    logic [3:0] dataWidth;
    logic       parityEnable;
    logic       parityType;
    logic [1:0] stopBits;
    logic       rxReady;
    logic [7:0] rxData;
    logic       rxParity;
    logic       parityError;
    logic       breakingError;
    logic       overrunError;
    logic       framingError;
    logic       rxValid;

    typedef struct packed {
        logic [7:0] data;
        logic       par;
        logic       pErr;
        logic       bErr;
        logic       oErr;
        logic       fErr;
    } expT;

    typedef struct {
        logic [4:0] os;
        logic [3:0] dw;
        logic       pe;
        logic       pt;
        logic [1:0] sb;
        logic [7:0] data;
        logic       parBit;
        logic       st1;
        logic       st2;
        int         extraLow;
        logic [7:0] expData;
        logic       expPar;
        logic       expPErr;
        logic       expBErr;
        logic       expFErr;
    } vecT;

    expT sbQ[$];
    int  checks      = 0;
    int  failures    = 0;
    int  validCycles = 0;
    int  wordIdx     = 0;
    int  pulseTick   = -1;

    uart_oversampled_receiver #(
        .DATA_WIDTH (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .baudTick     (baudTick),
        .rx           (rx),
        .overSampling (overSampling),
        .dataWidth    (dataWidth),
        .parityEnable (parityEnable),
        .parityType   (parityType),
        .stopBits     (stopBits),
        .rxReady      (rxReady),
        .rxData       (rxData),
        .rxParity     (rxParity),
        .parityError  (parityError),
        .breakingError(breakingError),
        .overrunError (overrunError),
        .framingError (framingError),
        .rxValid      (rxValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a word is compared when the consumer takes it
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            #2;
            if (rxValid === 1'b1) validCycles++;
            if (rxValid === 1'b1 && rxReady === 1'b1) begin
                if (sbQ.size() == 0) begin
                    check($sformatf("w%0d_unexpected", wordIdx), 32'd1, 32'd0);
                end else begin
                    e = sbQ.pop_front();
                    check($sformatf("w%0d_data", wordIdx), 32'(rxData), 32'(e.data));
                    check($sformatf("w%0d_parity", wordIdx), 32'(rxParity), 32'(e.par));
                    check($sformatf("w%0d_parityError", wordIdx), 32'(parityError), 32'(e.pErr));
                    check($sformatf("w%0d_breakingError", wordIdx), 32'(breakingError), 32'(e.bErr));
                    check($sformatf("w%0d_overrunError", wordIdx), 32'(overrunError), 32'(e.oErr));
                    check($sformatf("w%0d_framingError", wordIdx), 32'(framingError), 32'(e.fErr));
                end
                wordIdx++;
            end
        end
    end

    function automatic int effOs();
        return (overSampling == 5'd13) ? 13 : 16;
    endfunction

    function automatic int effDw();
        return (dataWidth >= 4'd5 && dataWidth <= 4'd8) ? int'(dataWidth) : 8;
    endfunction

    function automatic int effSb();
        return (stopBits == 2'd2) ? 2 : 1;
    endfunction

    // One oversample period of three clocks; optionally pulse rxReady for the
    // clock right after the tick
    task automatic doTick(input logic level, input int t);
        @(negedge clk);
        baudTick = 1'b1;
        rx       = level;
        @(negedge clk);
        baudTick = 1'b0;
        if (t == pulseTick) rxReady = 1'b1;
        @(negedge clk);
        if (t == pulseTick) rxReady = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) doTick(1'b1, -2);
    endtask

    // Drive one frame using the current configuration inputs. A low final
    // stop bit is released right after its sample point so the line reads
    // idle afterwards. abortTick >= 0 pulses reset at that frame tick.
    task automatic sendFrame(input logic [7:0] data, input logic parBit, input logic st1,
                             input logic st2, input int extraLow, input int abortTick);
        logic lv[$];
        int   os;
        int   dw;
        int   sb;
        int   mid;
        int   last;
        logic level;
        os  = effOs();
        dw  = effDw();
        sb  = effSb();
        mid = (os == 13) ? 6 : 8;
        lv.push_back(1'b0);
        for (int i = 0; i < dw; i++) lv.push_back(data[i]);
        if (parityEnable) lv.push_back(parBit);
        lv.push_back(st1);
        if (sb == 2) lv.push_back(st2);
        last = lv.size() - 1;
        for (int i = 0; i < extraLow; i++) lv.push_back(1'b0);
        for (int t = 0; t < lv.size() * os; t++) begin
            if (t == abortTick) begin
                @(negedge clk);
                baudTick = 1'b0;
                rx       = 1'b1;
                reset    = 1'b0;
                repeat (2) @(negedge clk);
                reset = 1'b1;
                return;
            end
            level = lv[t / os];
            if (extraLow == 0 && (t / os) == last && level == 1'b0 && (t % os) >= mid) level = 1'b1;
            doTick(level, t);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(sbQ.size()), 32'd0);
        sbQ.delete();
    endtask

    task automatic consumeOne();
        @(negedge clk);
        rxReady = 1'b1;
        @(negedge clk);
        rxReady = 1'b0;
    endtask

    task automatic set8N1();
        overSampling = 5'd16;
        dataWidth    = 4'd8;
        parityEnable = 1'b0;
        parityType   = 1'b0;
        stopBits     = 2'd1;
    endtask

    initial begin
        vecT vec[11];
        expT e;

        reset    = 1'b0;
        baudTick = 1'b0;
        rx       = 1'b1;
        rxReady  = 1'b1;
        set8N1();
        repeat (3) @(negedge clk);
        check("reset_rxValid", 32'(rxValid), 32'd0);
        check("reset_rxData", 32'(rxData), 32'd0);
        check("reset_rxParity", 32'(rxParity), 32'd0);
        check("reset_parityError", 32'(parityError), 32'd0);
        check("reset_breakingError", 32'(breakingError), 32'd0);
        check("reset_overrunError", 32'(overrunError), 32'd0);
        check("reset_framingError", 32'(framingError), 32'd0);
        reset = 1'b1;
        idle(4);

        //          os     dw    pe    pt    sb    data   par   st1   st2  xLow  expData  par   pErr  bErr  fErr
        vec[0]  = '{5'd16, 4'd8, 1'b0, 1'b0, 2'd1, 8'hA5, 1'b0, 1'b1, 1'b1, 0,  8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[1]  = '{5'd13, 4'd7, 1'b1, 1'b0, 2'd1, 8'h35, 1'b0, 1'b1, 1'b1, 0,  8'h35, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[2]  = '{5'd13, 4'd7, 1'b1, 1'b0, 2'd1, 8'h35, 1'b1, 1'b1, 1'b1, 0,  8'h35, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[3]  = '{5'd16, 4'd5, 1'b1, 1'b1, 2'd2, 8'h1F, 1'b0, 1'b1, 1'b0, 0,  8'h1F, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[4]  = '{5'd16, 4'd8, 1'b0, 1'b0, 2'd1, 8'h00, 1'b0, 1'b0, 1'b0, 2,  8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[5]  = '{5'd16, 4'd8, 1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 1'b0, 1'b0, 20, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[6]  = '{5'd7,  4'd12,1'b0, 1'b0, 2'd3, 8'hC3, 1'b0, 1'b1, 1'b1, 0,  8'hC3, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[7]  = '{5'd13, 4'd6, 1'b1, 1'b1, 2'd2, 8'h2A, 1'b1, 1'b1, 1'b1, 0,  8'h2A, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[8]  = '{5'd16, 4'd8, 1'b1, 1'b0, 2'd2, 8'h80, 1'b1, 1'b1, 1'b1, 0,  8'h80, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[9]  = '{5'd16, 4'd8, 1'b0, 1'b0, 2'd1, 8'h00, 1'b0, 1'b1, 1'b1, 0,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[10] = '{5'd13, 4'd6, 1'b0, 1'b0, 2'd1, 8'hFF, 1'b0, 1'b1, 1'b1, 0,  8'h3F, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            overSampling = vec[i].os;
            dataWidth    = vec[i].dw;
            parityEnable = vec[i].pe;
            parityType   = vec[i].pt;
            stopBits     = vec[i].sb;
            idle(8);
            validCycles = 0;
            e = '{data: vec[i].expData, par: vec[i].expPar, pErr: vec[i].expPErr,
                  bErr: vec[i].expBErr, oErr: 1'b0, fErr: vec[i].expFErr};
            sbQ.push_back(e);
            sendFrame(vec[i].data, vec[i].parBit, vec[i].st1, vec[i].st2, vec[i].extraLow, -1);
            idle(32);
            drain($sformatf("v%0d_drain", i));
            check($sformatf("v%0d_valid_cycles", i), 32'(validCycles), 32'd1);
        end

        // Overrun: two back-to-back frames with nobody consuming
        set8N1();
        rxReady = 1'b0;
        idle(8);
        sendFrame(8'h11, 1'b0, 1'b1, 1'b1, 0, -1);
        sendFrame(8'h22, 1'b0, 1'b1, 1'b1, 0, -1);
        idle(32);
        check("ovr_rxValid", 32'(rxValid), 32'd1);
        check("ovr_rxData", 32'(rxData), 32'h22);
        check("ovr_overrunError", 32'(overrunError), 32'd1);
        check("ovr_framingError", 32'(framingError), 32'd0);
        sbQ.push_back('{data: 8'h22, par: 1'b0, pErr: 1'b0, bErr: 1'b0, oErr: 1'b1, fErr: 1'b0});
        consumeOne();
        drain("ovr_drain");

        // Consume in the commit cycle: no overrun, new word stays valid.
        // The 8N1/OS16 stop sample falls on frame tick 8 + 16*9.
        idle(8);
        sendFrame(8'h33, 1'b0, 1'b1, 1'b1, 0, -1);
        idle(32);
        sbQ.push_back('{data: 8'h33, par: 1'b0, pErr: 1'b0, bErr: 1'b0, oErr: 1'b0, fErr: 1'b0});
        pulseTick = 8 + 16 * 9;
        sendFrame(8'h44, 1'b0, 1'b1, 1'b1, 0, -1);
        pulseTick = -1;
        idle(32);
        check("same_rxValid", 32'(rxValid), 32'd1);
        check("same_rxData", 32'(rxData), 32'h44);
        check("same_overrunError", 32'(overrunError), 32'd0);
        sbQ.push_back('{data: 8'h44, par: 1'b0, pErr: 1'b0, bErr: 1'b0, oErr: 1'b0, fErr: 1'b0});
        consumeOne();
        drain("same_drain");

        // Reset mid-frame (data bit 3) while an older word is still pending
        idle(8);
        sendFrame(8'h5A, 1'b0, 1'b1, 1'b1, 0, -1);
        idle(32);
        check("pend_rxValid", 32'(rxValid), 32'd1);
        sendFrame(8'h99, 1'b0, 1'b1, 1'b1, 0, 16 * 4 + 4);
        check("rst_rxValid", 32'(rxValid), 32'd0);
        check("rst_rxData", 32'(rxData), 32'd0);
        check("rst_flags", 32'({rxParity, parityError, breakingError, overrunError, framingError}), 32'd0);
        rxReady     = 1'b1;
        validCycles = 0;
        idle(40);
        check("rst_no_partial", 32'(validCycles), 32'd0);
        sbQ.push_back('{data: 8'h3C, par: 1'b0, pErr: 1'b0, bErr: 1'b0, oErr: 1'b0, fErr: 1'b0});
        sendFrame(8'h3C, 1'b0, 1'b1, 1'b1, 0, -1);
        idle(32);
        drain("rst_next_drain");

        // Glitch: 4 low ticks is a false start
        validCycles = 0;
        for (int i = 0; i < 4; i++) doTick(1'b0, -2);
        idle(40);
        check("glitch_no_word", 32'(validCycles), 32'd0);
        sbQ.push_back('{data: 8'h96, par: 1'b0, pErr: 1'b0, bErr: 1'b0, oErr: 1'b0, fErr: 1'b0});
        sendFrame(8'h96, 1'b0, 1'b1, 1'b1, 0, -1);
        idle(32);
        drain("glitch_next_drain");
        check("glitch_next_valid_cycles", 32'(validCycles), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
